// File: rtl/jclk_cfg_seq.sv
// jclk_cfg_seq: configuration sequencer for the clock generator divider
// registers CLK1 (processor/PLL), CLK2 (video/pixel) and CLK3 (chroma).
// After reset it waits RESET_WAIT cycles, writes the boot defaults to all
// three registers, then holds a settle lockout before accepting host writes.
// Host writes to CLK1/CLK2 are followed by another settle lockout; CLK3
// writes are not.
// Optional build macro JCLK_CFG_READBACK_EN adds shadow registers of the
// last value written to each register, readable through rd_sel/rd_data.
module jclk_cfg_seq #(
  parameter logic [15:0] CLK1_INIT     = 16'h0103,
  parameter logic [15:0] CLK2_INIT     = 16'h0002,
  parameter logic [15:0] CLK3_INIT     = 16'h8005,
  parameter int unsigned RESET_WAIT    = 16,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic [1:0]  host_sel,
  input  logic [15:0] host_data,
  output logic        host_ack,
  output logic        host_err,
  output logic        busy,
  output logic        boot_done,
  output logic        clk1w,
  output logic        clk2w,
  output logic        clk3w,
  output logic [15:0] dout,
  input  logic [1:0]  rd_sel,
  output logic [15:0] rd_data
);

  // Bits 14:10 do not exist in the generator registers and are always cleared.
  localparam logic [15:0] DataMask   = 16'h83FF;
  localparam logic [7:0]  ResetLast  = 8'(RESET_WAIT - 1);
  localparam logic [7:0]  SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    RST_WAIT,
    WR1,
    WR2,
    WR3,
    SETTLE,
    IDLE,
    HWR,
    HSETTLE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        errPend_q, errPend_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] data_q, data_d;

  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        bootDone_q, bootDone_d;
  logic        clk1w_q, clk1w_d;
  logic        clk2w_q, clk2w_d;
  logic        clk3w_q, clk3w_d;
  logic [15:0] dout_q, dout_d;
  logic        counting;

  // State register, lockout counter and the captured host request.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_WAIT;
      cnt_q     <= 8'd0;
      errPend_q <= 1'b0;
      sel_q     <= 2'd0;
      data_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      errPend_q <= errPend_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
    end
  end

  // Next-state logic; an invalid-select request is held one cycle in
  // errPend so its ack lands with the same latency as a real write.
  always_comb begin
    state_d   = state_q;
    errPend_d = 1'b0;
    sel_d     = sel_q;
    data_d    = data_q;
    case (state_q)
      RST_WAIT: if (cnt_q == ResetLast) state_d = WR1;
      WR1:      state_d = WR2;
      WR2:      state_d = WR3;
      WR3:      state_d = SETTLE;
      SETTLE:   if (cnt_q == SettleLast) state_d = IDLE;
      IDLE: begin
        if (host_req && !errPend_q) begin
          sel_d  = host_sel;
          data_d = host_data;
          if (host_sel == 2'd0) errPend_d = 1'b1;
          else                  state_d   = HWR;
        end
      end
      HWR:      state_d = (sel_q == 2'd3) ? IDLE : HSETTLE;
      HSETTLE:  if (cnt_q == SettleLast) state_d = IDLE;
      default:  state_d = RST_WAIT;
    endcase
  end

  // Counter runs only while waiting and restarts from 0 on every state change.
  always_comb begin
    counting = (state_q == RST_WAIT) || (state_q == SETTLE) || (state_q == HSETTLE);
    cnt_d    = 8'd0;
    if (counting && (state_d == state_q)) cnt_d = cnt_q + 8'd1;
  end

  // Output decode from the current state; the result is registered below.
  always_comb begin
    ack_d      = 1'b0;
    err_d      = 1'b0;
    busy_d     = 1'b1;
    bootDone_d = bootDone_q;
    clk1w_d    = 1'b0;
    clk2w_d    = 1'b0;
    clk3w_d    = 1'b0;
    dout_d     = 16'd0;
    case (state_q)
      WR1: begin
        clk1w_d = 1'b1;
        dout_d  = CLK1_INIT & DataMask;
      end
      WR2: begin
        clk2w_d = 1'b1;
        dout_d  = CLK2_INIT & DataMask;
      end
      WR3: begin
        clk3w_d = 1'b1;
        dout_d  = CLK3_INIT & DataMask;
      end
      IDLE: begin
        busy_d     = 1'b0;
        bootDone_d = 1'b1;
        ack_d      = errPend_q;
        err_d      = errPend_q;
      end
      HWR: begin
        ack_d   = 1'b1;
        clk1w_d = (sel_q == 2'd1);
        clk2w_d = (sel_q == 2'd2);
        clk3w_d = (sel_q == 2'd3);
        dout_d  = data_q & DataMask;
      end
      default: ;
    endcase
  end

  // Output registers; everything the generator and host see comes from here.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      bootDone_q <= 1'b0;
      clk1w_q    <= 1'b0;
      clk2w_q    <= 1'b0;
      clk3w_q    <= 1'b0;
      dout_q     <= 16'd0;
    end else begin
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      bootDone_q <= bootDone_d;
      clk1w_q    <= clk1w_d;
      clk2w_q    <= clk2w_d;
      clk3w_q    <= clk3w_d;
      dout_q     <= dout_d;
    end
  end

  assign host_ack  = ack_q;
  assign host_err  = err_q;
  assign busy      = busy_q;
  assign boot_done = bootDone_q;
  assign clk1w     = clk1w_q;
  assign clk2w     = clk2w_q;
  assign clk3w     = clk3w_q;
  assign dout      = dout_q;

`ifdef JCLK_CFG_READBACK_EN
  logic [15:0] shadow1_q, shadow2_q, shadow3_q;
  logic [15:0] rdData_q, rdData_d;

  // Shadow copies follow every strobe, boot or host, with the masked data.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      shadow1_q <= 16'd0;
      shadow2_q <= 16'd0;
      shadow3_q <= 16'd0;
    end else begin
      if (clk1w_d) shadow1_q <= dout_d;
      if (clk2w_d) shadow2_q <= dout_d;
      if (clk3w_d) shadow3_q <= dout_d;
    end
  end

  // Readback mux; select 0 reads as zero.
  always_comb begin
    rdData_d = 16'd0;
    case (rd_sel)
      2'd1:    rdData_d = shadow1_q;
      2'd2:    rdData_d = shadow2_q;
      2'd3:    rdData_d = shadow3_q;
      default: rdData_d = 16'd0;
    endcase
  end

  // Registered readback gives one cycle of latency from rd_sel.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) rdData_q <= 16'd0;
    else       rdData_q <= rdData_d;
  end

  assign rd_data = rdData_q;
`else
  logic unusedRdSel;
  assign unusedRdSel = ^rd_sel;
  assign rd_data     = 16'd0;
`endif

endmodule

// File: tb/tb_jclk_cfg_seq.sv
// tb_jclk_cfg_seq: self-checking bench for jclk_cfg_seq. Expected outputs
// come from timing rules (boot write cycles, one-cycle request latency,
// lockout length) and a per-register shadow model, not from the DUT.
module tb_jclk_cfg_seq;

  localparam int          ResetWait    = 16;
  localparam int          SettleCycles = 64;
  localparam logic [15:0] Clk1Init     = 16'h0103;
  localparam logic [15:0] Clk2Init     = 16'h0002;
  localparam logic [15:0] Clk3Init     = 16'h8005;
  localparam logic [15:0] DataMask     = 16'h83FF;
  localparam int          IdleAt       = ResetWait + SettleCycles + 4;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        host_req = 1'b0;
  logic [1:0]  host_sel = 2'd0;
  logic [15:0] host_data = 16'd0;
  logic [1:0]  rd_sel = 2'd0;
  logic        host_ack, host_err, busy, boot_done;
  logic        clk1w, clk2w, clk3w;
  logic [15:0] dout, rd_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] shadowModel [4];

  always #5 sys_clk = ~sys_clk;

  jclk_cfg_seq dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .host_req  (host_req),
    .host_sel  (host_sel),
    .host_data (host_data),
    .host_ack  (host_ack),
    .host_err  (host_err),
    .busy      (busy),
    .boot_done (boot_done),
    .clk1w     (clk1w),
    .clk2w     (clk2w),
    .clk3w     (clk3w),
    .dout      (dout),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data)
  );

  wire [22:0] observedVec = {clk1w, clk2w, clk3w, host_ack, host_err, busy, boot_done, dout};

  function automatic logic [22:0] packExp(input logic [2:0] strobes, input logic ack,
                                          input logic err, input logic bsy,
                                          input logic boot, input logic [15:0] d);
    return {strobes, ack, err, bsy, boot, d};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [22:0] expected);
    vectors++;
    assert (observedVec === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observedVec, expected);
    end
  endtask

  task automatic checkReadback(input string tag, input logic [1:0] sel);
    logic [15:0] expected;
    rd_sel = sel;
    tick();
`ifdef JCLK_CFG_READBACK_EN
    expected = (sel == 2'd0) ? 16'd0 : shadowModel[sel];
`else
    expected = 16'd0;
`endif
    vectors++;
    assert (rd_data === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s rd_sel=%0d observed=%h expected=%h", tag, sel, rd_data, expected);
    end
  endtask

  task automatic runBoot(input string tag);
    logic [2:0]  st;
    logic [15:0] d;
    @(negedge sys_clk);
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= IdleAt; k++) begin
      tick();
      st = 3'b000;
      d  = 16'd0;
      if (k == ResetWait + 1) begin st = 3'b100; d = Clk1Init & DataMask; end
      if (k == ResetWait + 2) begin st = 3'b010; d = Clk2Init & DataMask; end
      if (k == ResetWait + 3) begin st = 3'b001; d = Clk3Init & DataMask; end
      checkOutput(tag, packExp(st, 1'b0, 1'b0, k < IdleAt, k >= IdleAt, d));
    end
    shadowModel[0] = 16'd0;
    shadowModel[1] = Clk1Init & DataMask;
    shadowModel[2] = Clk2Init & DataMask;
    shadowModel[3] = Clk3Init & DataMask;
  endtask

  task automatic expectLockout(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, packExp(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0));
    end
  endtask

  task automatic expectAckCycle(input string tag, input logic [1:0] sel, input logic [15:0] data);
    logic [2:0] st;
    st = {sel == 2'd1, sel == 2'd2, sel == 2'd3};
    tick();
    checkOutput(tag, packExp(st, 1'b1, sel == 2'd0, sel != 2'd0, 1'b1,
                             (sel == 2'd0) ? 16'd0 : (data & DataMask)));
    if (sel != 2'd0) shadowModel[sel] = data & DataMask;
  endtask

  // One complete host transaction started while the DUT is idle.
  task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] data);
    host_req  = 1'b1;
    host_sel  = sel;
    host_data = data;
    tick();
    checkOutput("req-sample", packExp(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    expectAckCycle("req-ack", sel, data);
    host_req  = 1'b0;
    host_sel  = 2'($urandom);
    host_data = 16'($urandom);
    if (sel == 2'd1 || sel == 2'd2) expectLockout("lockout", SettleCycles);
    tick();
    checkOutput("back-idle", packExp(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
  endtask

  initial begin
    int raiseAt;
    logic [1:0]  rsel;
    logic [15:0] rdata;
    logic [15:0] lateData;

    $display("[TB] jclk_cfg_seq bench start");
    #2 reset = 1'b1;
    #1 checkOutput("reset-state", 23'd0);
    tick();
    tick();
    runBoot("boot");

    applyStimulus(2'd3, 16'hFFFF);
    checkReadback("rb-clk3", 2'd3);
    checkReadback("rb-clk1", 2'd1);

    applyStimulus(2'd0, 16'h1234);
    checkReadback("rb-after-err", 2'd2);
    checkReadback("rb-sel0", 2'd0);

    host_req  = 1'b1;
    host_sel  = 2'd2;
    host_data = 16'h0010;
    tick();
    checkOutput("lk-sample", packExp(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    expectAckCycle("lk-ack", 2'd2, 16'h0010);
    host_req = 1'b0;
    raiseAt  = int'($urandom_range(1, SettleCycles - 4));
    lateData = 16'($urandom);
    expectLockout("lk-pre", raiseAt);
    host_req  = 1'b1;
    host_sel  = 2'd1;
    host_data = lateData;
    expectLockout("lk-held", SettleCycles - raiseAt);
    tick();
    checkOutput("lk-idle", packExp(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    expectAckCycle("lk-late-ack", 2'd1, lateData);
    host_req = 1'b0;
    expectLockout("lk-second", SettleCycles);
    tick();
    checkOutput("lk-done", packExp(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    checkReadback("rb-late", 2'd1);

    for (int t = 0; t < 10; t++) begin
      rsel  = 2'($urandom_range(0, 3));
      rdata = 16'($urandom);
      applyStimulus(rsel, rdata);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tick();
        checkOutput("gap-idle", packExp(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
      end
      checkReadback("rb-random", 2'($urandom_range(0, 3)));
    end

    host_req  = 1'b1;
    host_sel  = 2'd1;
    host_data = 16'hABCD;
    tick();
    expectAckCycle("rst-ack", 2'd1, 16'hABCD);
    host_req = 1'b0;
    expectLockout("rst-lockout", 5);
    host_req  = 1'b1;
    host_sel  = 2'd3;
    #2 reset = 1'b1;
    #1 checkOutput("async-reset", 23'd0);
    tick();
    host_req = 1'b0;
    runBoot("reboot");
    checkReadback("rb-reboot", 2'd1);
    checkReadback("rb-reboot3", 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
